// File: rtl/floor_request_scheduler_if.sv
// Request/target bus between keypad decoder, floor_request_scheduler and motion controller.
// The scheduler connects on the slave modport; the requester/observer side uses master.
interface floor_request_scheduler_if #(
    parameter int NUM_FLOORS = 4
);
    localparam int FLOOR_W = $clog2(NUM_FLOORS);

    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  dir_up;
    logic                  dir_down;

    modport master (
        output req_valid, req_floor, cur_floor, arrive,
        input  pending, target_floor, target_valid, dir_up, dir_down
    );

    modport slave (
        input  req_valid, req_floor, cur_floor, arrive,
        output pending, target_floor, target_valid, dir_up, dir_down
    );
endinterface

// File: rtl/floor_request_scheduler.sv
// Per-floor request latches plus a SCAN-ordered UP/DOWN/IDLE direction FSM
// that picks the next floor for the car motion controller.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no direction committed; only a request at cur_floor is served
// ST_UP   | moving up, target is the lowest pending floor above the car
// ST_DOWN | moving down, target is the highest pending floor below the car
module floor_request_scheduler #(
    parameter int NUM_FLOORS = 4
) (
    input logic                     Clock,
    input logic                     Reset,
    floor_request_scheduler_if.slave bus
);
    localparam int FLOOR_W = $clog2(NUM_FLOORS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  dir_up_q, dir_down_q;

    logic                  above, below, here;
    logic [FLOOR_W-1:0]    up_tgt, down_tgt;
    logic                  up_found, down_found;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;

    // Clear wins over set so a request for the floor being serviced is dropped.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (bus.arrive && (bus.cur_floor == FLOOR_W'(i))) begin
                pending_d[i] = 1'b0;
            end else if (bus.req_valid && (bus.req_floor == FLOOR_W'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Ascending loop, last hit wins: highest below. Descending: lowest above.
    always_comb begin
        above      = 1'b0;
        below      = 1'b0;
        here       = 1'b0;
        down_found = 1'b0;
        down_tgt   = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (FLOOR_W'(i) > bus.cur_floor) above = 1'b1;
                if (FLOOR_W'(i) == bus.cur_floor) here = 1'b1;
                if (FLOOR_W'(i) < bus.cur_floor) begin
                    below      = 1'b1;
                    down_found = 1'b1;
                    down_tgt   = FLOOR_W'(i);
                end
            end
        end
        up_found = 1'b0;
        up_tgt   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) > bus.cur_floor)) begin
                up_found = 1'b1;
                up_tgt   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = above ? ST_UP : (below ? ST_DOWN : ST_IDLE);
            ST_UP:   state_d = above ? ST_UP : (below ? ST_DOWN : ST_IDLE);
            ST_DOWN: state_d = below ? ST_DOWN : (above ? ST_UP : ST_IDLE);
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending_q  <= '0;
            state_q    <= ST_IDLE;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            state_q    <= state_d;
            dir_up_q   <= (state_d == ST_UP);
            dir_down_q <= (state_d == ST_DOWN);
        end
    end

    // A request at the current floor always stops the car first.
    always_comb begin
        target_floor = bus.cur_floor;
        target_valid = 1'b0;
        if (here) begin
            target_valid = 1'b1;
        end else begin
            case (state_q)
                ST_UP: begin
                    target_valid = up_found;
                    if (up_found) target_floor = up_tgt;
                end
                ST_DOWN: begin
                    target_valid = down_found;
                    if (down_found) target_floor = down_tgt;
                end
                default: target_valid = 1'b0;
            endcase
        end
    end

    assign bus.pending      = pending_q;
    assign bus.target_floor = target_floor;
    assign bus.target_valid = target_valid;
    assign bus.dir_up       = dir_up_q;
    assign bus.dir_down     = dir_down_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: a 4-floor instance for the main
// SCAN sequence and a 5-floor instance for out-of-range index handling.
module tb_floor_request_scheduler;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 Clock = ~Clock;

    floor_request_scheduler_if #(.NUM_FLOORS(4)) bus4 ();
    floor_request_scheduler_if #(.NUM_FLOORS(5)) bus5 ();

    floor_request_scheduler #(.NUM_FLOORS(4)) dut4 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus4)
    );

    floor_request_scheduler #(.NUM_FLOORS(5)) dut5 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus5)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic req4(input int f);
        bus4.req_valid = 1'b1;
        bus4.req_floor = 2'(f);
        tick();
        bus4.req_valid = 1'b0;
    endtask

    initial begin
        bus4.req_valid = 0; bus4.req_floor = 0; bus4.cur_floor = 0; bus4.arrive = 0;
        bus5.req_valid = 0; bus5.req_floor = 0; bus5.cur_floor = 0; bus5.arrive = 0;
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        repeat (5) tick();
        check("rst_pending", int'(bus4.pending), 0);
        check("rst_tvalid", int'(bus4.target_valid), 0);
        check("rst_tfloor", int'(bus4.target_floor), 0);
        check("rst_up", int'(bus4.dir_up), 0);
        check("rst_down", int'(bus4.dir_down), 0);

        // Request floor 2 from floor 0: latch at N+1, UP at N+2.
        bus4.cur_floor = 0;
        req4(2);
        check("req_latency_pend", int'(bus4.pending), 4);
        check("req_latency_up", int'(bus4.dir_up), 0);
        check("idle_no_here_tv", int'(bus4.target_valid), 0);
        tick();
        check("up_state", int'(bus4.dir_up), 1);
        check("up_target", int'(bus4.target_floor), 2);
        check("up_tvalid", int'(bus4.target_valid), 1);

        // Arrive and request for the same floor: clear wins.
        bus4.cur_floor = 2; bus4.arrive = 1; bus4.req_valid = 1; bus4.req_floor = 2;
        #1;
        check("here_target", int'(bus4.target_floor), 2);
        check("here_tvalid", int'(bus4.target_valid), 1);
        tick();
        bus4.arrive = 0; bus4.req_valid = 0;
        check("clr_prio_pend", int'(bus4.pending), 0);
        check("clr_prio_idle", int'(bus4.dir_up), 0);

        // Load floors 3 and 0 from floor 3 so the FSM stays IDLE.
        bus4.cur_floor = 3;
        req4(3);
        req4(0);
        check("load_1001", int'(bus4.pending), 9);
        check("load_idle_up", int'(bus4.dir_up), 0);
        check("load_idle_dn", int'(bus4.dir_down), 0);
        bus4.cur_floor = 2;
        #1;
        check("idle_tv_off", int'(bus4.target_valid), 0);
        tick();
        check("tie_up", int'(bus4.dir_up), 1);
        check("tie_target", int'(bus4.target_floor), 3);

        bus4.cur_floor = 1;
        tick();
        check("scan_up_tgt", int'(bus4.target_floor), 3);
        check("scan_up_state", int'(bus4.dir_up), 1);
        bus4.cur_floor = 3; bus4.arrive = 1;
        tick();
        bus4.arrive = 0;
        check("arr3_pend", int'(bus4.pending), 1);
        check("arr3_down", int'(bus4.dir_down), 1);
        check("arr3_up_off", int'(bus4.dir_up), 0);
        check("down_target", int'(bus4.target_floor), 0);
        check("down_tvalid", int'(bus4.target_valid), 1);
        bus4.cur_floor = 0; bus4.arrive = 1;
        tick();
        bus4.arrive = 0;
        check("arr0_pend", int'(bus4.pending), 0);
        check("arr0_down_off", int'(bus4.dir_down), 0);
        check("arr0_tvalid", int'(bus4.target_valid), 0);

        // All floors pending while moving DOWN, then reset with a request.
        bus4.cur_floor = 3;
        req4(0); req4(1); req4(2); req4(3);
        check("all_pend", int'(bus4.pending), 15);
        check("all_down", int'(bus4.dir_down), 1);
        Reset = 1; bus4.req_valid = 1; bus4.req_floor = 1;
        tick();
        Reset = 0; bus4.req_valid = 0; bus4.cur_floor = 0;
        #1;
        check("mid_rst_pend", int'(bus4.pending), 0);
        check("mid_rst_down", int'(bus4.dir_down), 0);
        check("mid_rst_up", int'(bus4.dir_up), 0);
        check("mid_rst_tv", int'(bus4.target_valid), 0);
        check("mid_rst_tf", int'(bus4.target_floor), 0);

        // 5-floor instance: indices 5..7 must not touch any latch.
        bus5.req_valid = 1; bus5.req_floor = 3'd5;
        tick();
        bus5.req_floor = 3'd7;
        tick();
        bus5.req_valid = 0;
        check("oor_req", int'(bus5.pending), 0);
        bus5.req_valid = 1; bus5.req_floor = 3'd4;
        tick();
        bus5.req_valid = 0;
        check("top_req", int'(bus5.pending), 16);
        bus5.cur_floor = 3'd6; bus5.arrive = 1;
        tick();
        bus5.arrive = 0;
        check("oor_arrive", int'(bus5.pending), 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
